bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning bus data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning WAIT-state cycle limit; used only with BUS_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 m0_req, m1_req  in  1 each  requester 0 (CPU control unit) and requester 1 (debug/loader) wants a transaction.
REQ-007 m0_mode, m1_mode  in  1 each  0 = read, 1 = write.
REQ-008 m0_addr, m1_addr  in  ADDR_W each  transaction address.
REQ-009 m0_wdata, m1_wdata  in  DATA_W each  write data.
REQ-010 m0_gnt, m1_gnt  out  1 each  requester owns the bus.
REQ-011 m0_done, m1_done  out  1 each  one-cycle completion pulse to owner.
REQ-012 m_rdata  out  DATA_W  read data shared by both requesters; valid only with the owner's done pulse on a read.
REQ-013 bus_start_transaction  out  1  one-cycle transaction start pulse.
REQ-014 bus_mode  out  1  latched mode.
REQ-015 bus_addr  out  ADDR_W  latched address.
REQ-016 bus_wdata  out  DATA_W  latched write data.
REQ-017 bus_rdata  in  DATA_W  read data from the bus.
REQ-018 bus_rdata_valid  in  1  read completion.
REQ-019 bus_write_done  in  1  write completion.
REQ-020 owner  out  1  index of the last or current owner.
REQ-021 busy  out  1  FSM not in IDLE.
REQ-022 timeout_err  out  1  sticky timeout flag.

Function
REQ-023 FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-024 IDLE: with any req sampled high, SHALL select a winner, latch its mode/addr/wdata into bus_* registers, set owner, and go to ISSUE next cycle; with no req, SHALL stay in IDLE.
REQ-025 Arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins; after reset, m0 has priority.
REQ-026 ISSUE: bus_start_transaction SHALL be 1 for exactly this one cycle; FSM SHALL go to WAIT.
REQ-027 mX_gnt SHALL be high in ISSUE and WAIT for the owner only; both grants SHALL be 0 in IDLE.
REQ-028 WAIT: read SHALL complete on bus_rdata_valid; write SHALL complete on bus_write_done; the non-matching completion SHALL be ignored.
REQ-029 On completion, owner's mX_done SHALL pulse in the same cycle (combinational); m_rdata SHALL equal bus_rdata in that cycle; FSM SHALL return to IDLE next cycle.
REQ-030 Completion inputs in IDLE or ISSUE SHALL be ignored.
REQ-031 Latency: req high at edge N gives start pulse in cycle N+1; next arbitration SHALL be no earlier than the cycle after done.
REQ-032 Owner dropping req mid-transaction SHALL NOT abort it; done SHALL still pulse.
REQ-033 bus_addr, bus_mode and bus_wdata SHALL stay stable from ISSUE until return to IDLE.

Reset
REQ-034 rst SHALL force IDLE, owner=0, m0 priority, bus_start_transaction=0, bus_mode=0, bus_addr=0, bus_wdata=0, all gnt/done=0, busy=0, timeout_err=0, including mid-transaction; a pending bus completion SHALL then be dropped.

Configuration
REQ-035 With BUS_ARB_TIMEOUT_EN defined, a counter SHALL clear on ISSUE and increment each WAIT cycle; at TIMEOUT cycles without completion, owner's done SHALL pulse with m_rdata=0, timeout_err SHALL set (sticky until rst), and FSM SHALL go to IDLE.
REQ-036 Without BUS_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter SHALL exist, and timeout_err SHALL be tied 0.

Verification
REQ-037 m0 read addr=0x10, bus_rdata=0xDEADBEEF returned 3 cycles after start -> one start pulse, m0_gnt through WAIT, m0_done with m_rdata=0xDEADBEEF.
REQ-038 m0 and m1 both request continuously -> grants alternate m0, m1, m0, m1; no start while busy.
REQ-039 m1 write addr=0x20, wdata=0x5A5A5A5A; stray bus_rdata_valid in WAIT -> ignored; completes only on bus_write_done.
REQ-040 rst asserted during WAIT -> next cycle IDLE, all outputs at reset values; subsequent m1 request granted normally.
REQ-041 With BUS_ARB_TIMEOUT_EN and TIMEOUT=8, no completion -> m0_done 8 cycles into WAIT, timeout_err=1 held until rst.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: two requester ports plus the shared downstream bus.
// master = arbiter view, slave = requesters/bus environment view.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_mode;
  logic              m1_mode;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_gnt;
  logic              m1_gnt;
  logic              m0_done;
  logic              m1_done;
  logic [DATA_W-1:0] m_rdata;
  logic              bus_start_transaction;
  logic              bus_mode;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rdata_valid;
  logic              bus_write_done;
  logic              owner;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  m0_req, m1_req, m0_mode, m1_mode, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  bus_rdata, bus_rdata_valid, bus_write_done,
    output m0_gnt, m1_gnt, m0_done, m1_done, m_rdata,
    output bus_start_transaction, bus_mode, bus_addr, bus_wdata,
    output owner, busy, timeout_err
  );

  modport slave (
    output m0_req, m1_req, m0_mode, m1_mode, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output bus_rdata, bus_rdata_valid, bus_write_done,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m_rdata,
    input  bus_start_transaction, bus_mode, bus_addr, bus_wdata,
    input  owner, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with IDLE/ISSUE/WAIT transaction FSM.
// Optional WAIT-state timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              prio_q, prio_d;   // 1: m1 wins a tie
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              winner_c;
  logic              complete_c;
  logic              timeout_c;
  logic              done_c;

`ifdef BUS_ARB_TIMEOUT_EN
  // Counter holds 0..TIMEOUT-1 WAIT cycles
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              terr_q, terr_d;
`endif

  // State and latched transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // Arbitration, next-state and completion decode
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    complete_c = 1'b0;
    timeout_c  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    terr_d     = terr_q;
`endif
    winner_c   = (bif.m0_req && bif.m1_req) ? prio_q : bif.m1_req;

    case (state_q)
      IDLE: begin
        if (bif.m0_req || bif.m1_req) begin
          owner_d = winner_c;
          prio_d  = ~winner_c;
          mode_d  = winner_c ? bif.m1_mode  : bif.m0_mode;
          addr_d  = winner_c ? bif.m1_addr  : bif.m0_addr;
          wdata_d = winner_c ? bif.m1_wdata : bif.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        // Only the completion matching the latched mode counts
        complete_c = mode_q ? bif.bus_write_done : bif.bus_rdata_valid;
        if (complete_c) begin
          state_d = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          terr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A completion arriving together with reset is dropped
    done_c = (complete_c || timeout_c) && !rst;
  end

  assign bif.m0_gnt                = (state_q != IDLE) && !owner_q;
  assign bif.m1_gnt                = (state_q != IDLE) &&  owner_q;
  assign bif.m0_done               = done_c && !owner_q;
  assign bif.m1_done               = done_c &&  owner_q;
  assign bif.m_rdata               = (complete_c && !rst) ? bif.bus_rdata : '0;
  assign bif.bus_start_transaction = (state_q == ISSUE);
  assign bif.bus_mode              = mode_q;
  assign bif.bus_addr              = addr_q;
  assign bif.bus_wdata             = wdata_q;
  assign bif.owner                 = owner_q;
  assign bif.busy                  = (state_q != IDLE);
`ifdef BUS_ARB_TIMEOUT_EN
  assign bif.timeout_err           = terr_q;
`else
  // Timeout logic compiled out; flag permanently clear
  assign bif.timeout_err           = 1'b0 & (TIMEOUT != 0);
`endif

endmodule
